// File: rtl/mem_stage_pkg.sv
// Shared instruction ids, widths and the load/store class decoder used by the MEM stage.
package mem_stage_pkg;

  localparam int WIDTH_INSTR = 6;
  localparam int WIDTH_T     = 2;

  localparam logic [WIDTH_INSTR-1:0] I_NOP = 6'd0;
  localparam logic [WIDTH_INSTR-1:0] I_ADD = 6'd1;
  localparam logic [WIDTH_INSTR-1:0] I_LW  = 6'd2;
  localparam logic [WIDTH_INSTR-1:0] I_LH  = 6'd3;
  localparam logic [WIDTH_INSTR-1:0] I_LHU = 6'd4;
  localparam logic [WIDTH_INSTR-1:0] I_LB  = 6'd5;
  localparam logic [WIDTH_INSTR-1:0] I_LBU = 6'd6;
  localparam logic [WIDTH_INSTR-1:0] I_SW  = 6'd7;
  localparam logic [WIDTH_INSTR-1:0] I_SH  = 6'd8;
  localparam logic [WIDTH_INSTR-1:0] I_SB  = 6'd9;
  localparam logic [WIDTH_INSTR-1:0] I_ORI = 6'd10;

  // Bit positions in the decoder's function mask
  localparam int FUNC_MEM_READ  = 0;
  localparam int FUNC_MEM_WRITE = 1;

  typedef enum logic [1:0] {SZ_W, SZ_H, SZ_B} mem_size_e;

  function automatic logic [1:0] ic_func(logic [WIDTH_INSTR-1:0] instr);
    logic [1:0] f;
    f = '0;
    case (instr)
      I_LW, I_LH, I_LHU, I_LB, I_LBU: f[FUNC_MEM_READ]  = 1'b1;
      I_SW, I_SH, I_SB:               f[FUNC_MEM_WRITE] = 1'b1;
      default:                        f = '0;
    endcase
    return f;
  endfunction

  function automatic mem_size_e mem_size(logic [WIDTH_INSTR-1:0] instr);
    case (instr)
      I_LH, I_LHU, I_SH: return SZ_H;
      I_LB, I_LBU, I_SB: return SZ_B;
      default:           return SZ_W;
    endcase
  endfunction

endpackage

// File: rtl/mem_stage_dm_ram.sv
// Word-organised data memory: byte-enable write, asynchronous read, synchronous clear.
module dm_ram #(
  parameter int DEPTH = 1024,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          we,
  input  logic [3:0]    be,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (we) begin
      for (int l = 0; l < 4; l++) begin
        if (be[l]) mem_q[addr][8*l +: 8] <= wdata[8*l +: 8];
      end
    end
  end

  assign rdata = mem_q[addr];

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: data memory access, lane merge / load extension, EX forwarding
// and the MEM->WB pipeline register.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int          DEPTH     = 1024,
  parameter logic [31:0] ADDR_BASE = 32'h0000_0000
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   stall,
  input  logic                   clr,
  input  logic [WIDTH_INSTR-1:0] instr_mem,
  input  logic [31:0]            pc_mem,
  input  logic [31:0]            alu_out_mem,
  input  logic [31:0]            mem_write_data_mem,
  input  logic [4:0]             addr_rt_mem,
  input  logic [4:0]             reg_write_addr_mem,
  input  logic [31:0]            reg_write_data_mem,
  input  logic [WIDTH_T-1:0]     tnew_mem,
  input  logic [4:0]             regaddr_wb,
  input  logic [31:0]            regdata_wb,
  output logic [4:0]             regaddr_fwd,
  output logic [31:0]            regdata_fwd,
  output logic [WIDTH_INSTR-1:0] instr_wb,
  output logic [31:0]            pc_wb,
  output logic [4:0]             reg_write_addr_wb,
  output logic [31:0]            reg_write_data_wb,
  output logic [WIDTH_T-1:0]     tnew_wb,
  output logic                   mem_we,
  output logic [31:0]            mem_addr,
  output logic [31:0]            mem_wdata,
  output logic                   addr_err
);

  localparam int AW = $clog2(DEPTH);

  logic [1:0]    func;
  logic          is_ld, is_st, sext;
  mem_size_e     sz;
  logic [31:0]   offset, rt, rd_word, wdata_rep, load_data;
  logic [1:0]    lane;
  logic [AW-1:0] word_idx;
  logic          in_range, misalign;
  logic [3:0]    be;
  logic [15:0]   half_sel;
  logic [7:0]    byte_sel;

  assign func     = ic_func(instr_mem);
  assign is_ld    = func[FUNC_MEM_READ];
  assign is_st    = func[FUNC_MEM_WRITE];
  assign sz       = mem_size(instr_mem);
  assign sext     = (instr_mem == I_LH) || (instr_mem == I_LB);

  assign offset   = alu_out_mem - ADDR_BASE;
  assign lane     = offset[1:0];
  assign word_idx = offset[AW+1:2];
  assign in_range = offset < 32'(4 * DEPTH);
  assign misalign = ((sz == SZ_W) && (lane != 2'd0)) || ((sz == SZ_H) && lane[0]);
  assign addr_err = (is_ld || is_st) && (!in_range || misalign);

  // The WB stage may be writing rt this very cycle; its value is newer than EX's copy
  assign rt = (regaddr_wb == addr_rt_mem && regaddr_wb != 5'd0) ? regdata_wb
                                                                : mem_write_data_mem;

  always_comb begin
    be = 4'b0000;
    case (sz)
      SZ_W:    be = 4'b1111;
      SZ_H:    be = lane[1] ? 4'b1100 : 4'b0011;
      SZ_B:    be = 4'b0001 << lane;
      default: be = 4'b0000;
    endcase
  end

  assign mem_we   = !reset && !stall && is_st && !addr_err;
  assign mem_addr = {alu_out_mem[31:2], 2'b00};

  dm_ram #(.DEPTH(DEPTH), .AW(AW)) u_dm_ram (
    .clk   (clk),
    .reset (reset),
    .we    (mem_we),
    .be    (be),
    .addr  (word_idx),
    .wdata (wdata_rep),
    .rdata (rd_word)
  );

  // Store data replicated onto every lane it could occupy; be picks the live ones
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign wdata_rep[8*gi +: 8] = (sz == SZ_W) ? rt[8*gi +: 8]
                                : (sz == SZ_H) ? rt[8*(gi%2) +: 8]
                                :                rt[7:0];
    assign mem_wdata[8*gi +: 8] = be[gi] ? wdata_rep[8*gi +: 8] : rd_word[8*gi +: 8];
  end

  assign half_sel = lane[1] ? rd_word[31:16] : rd_word[15:0];
  always_comb begin
    byte_sel = rd_word[7:0];
    case (lane)
      2'd1:    byte_sel = rd_word[15:8];
      2'd2:    byte_sel = rd_word[23:16];
      2'd3:    byte_sel = rd_word[31:24];
      default: byte_sel = rd_word[7:0];
    endcase
  end

  always_comb begin
    load_data = '0;
    if (!addr_err) begin
      case (sz)
        SZ_H:    load_data = {{16{sext & half_sel[15]}}, half_sel};
        SZ_B:    load_data = {{24{sext & byte_sel[7]}}, byte_sel};
        default: load_data = rd_word;
      endcase
    end
  end

  assign regaddr_fwd = (tnew_mem == '0) ? reg_write_addr_mem : 5'd0;
  assign regdata_fwd = reg_write_data_mem;

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      instr_wb          <= '0;
      pc_wb             <= '0;
      reg_write_addr_wb <= '0;
      reg_write_data_wb <= '0;
      tnew_wb           <= '0;
    end else if (!stall) begin
      instr_wb          <= instr_mem;
      pc_wb             <= pc_mem;
      reg_write_addr_wb <= reg_write_addr_mem;
      reg_write_data_wb <= is_ld ? load_data : reg_write_data_mem;
      tnew_wb           <= (tnew_mem != '0) ? tnew_mem - WIDTH_T'(1) : '0;
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed cases plus randomized traffic against
// a byte-addressed reference memory and a MEM->WB register model.
module tb_mem_stage;
  import mem_stage_pkg::*;

  localparam int          DEPTH = 1024;
  localparam logic [31:0] BASE  = 32'h0000_0000;
  localparam int          NBYTE = 4 * DEPTH;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                   reset, stall, clr;
  logic [WIDTH_INSTR-1:0] instr_mem;
  logic [31:0]            pc_mem, alu_out_mem, mem_write_data_mem, reg_write_data_mem, regdata_wb;
  logic [4:0]             addr_rt_mem, reg_write_addr_mem, regaddr_wb;
  logic [WIDTH_T-1:0]     tnew_mem;
  logic [4:0]             regaddr_fwd, reg_write_addr_wb;
  logic [31:0]            regdata_fwd, pc_wb, reg_write_data_wb, mem_addr, mem_wdata;
  logic [WIDTH_INSTR-1:0] instr_wb;
  logic [WIDTH_T-1:0]     tnew_wb;
  logic                   mem_we, addr_err;

  mem_stage #(.DEPTH(DEPTH), .ADDR_BASE(BASE)) dut (
    .clk(clk), .reset(reset), .stall(stall), .clr(clr),
    .instr_mem(instr_mem), .pc_mem(pc_mem), .alu_out_mem(alu_out_mem),
    .mem_write_data_mem(mem_write_data_mem), .addr_rt_mem(addr_rt_mem),
    .reg_write_addr_mem(reg_write_addr_mem), .reg_write_data_mem(reg_write_data_mem),
    .tnew_mem(tnew_mem), .regaddr_wb(regaddr_wb), .regdata_wb(regdata_wb),
    .regaddr_fwd(regaddr_fwd), .regdata_fwd(regdata_fwd),
    .instr_wb(instr_wb), .pc_wb(pc_wb), .reg_write_addr_wb(reg_write_addr_wb),
    .reg_write_data_wb(reg_write_data_wb), .tnew_wb(tnew_wb),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .addr_err(addr_err)
  );

  int tests = 0;
  int fails = 0;

  logic [7:0] mb [NBYTE];
  logic [WIDTH_INSTR-1:0] m_instr;
  logic [31:0]            m_pc, m_wd;
  logic [4:0]             m_wa;
  logic [WIDTH_T-1:0]     m_tn;

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%08h exp=%08h @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic set(logic [WIDTH_INSTR-1:0] op, logic [31:0] addr, logic [31:0] wd,
                     logic [4:0] rta = 5'd0, logic [4:0] wba = 5'd0, logic [31:0] wbd = 32'd0,
                     logic [4:0] wa = 5'd0, logic [31:0] rdm = 32'd0, logic [WIDTH_T-1:0] tn = 1);
    instr_mem = op; alu_out_mem = addr; mem_write_data_mem = wd;
    addr_rt_mem = rta; regaddr_wb = wba; regdata_wb = wbd;
    reg_write_addr_mem = wa; reg_write_data_mem = rdm; tnew_mem = tn;
    pc_mem = pc_mem + 32'd4;
    reset = 1'b0; stall = 1'b0; clr = 1'b0;
  endtask

  // One cycle: check combinational outputs, clock, update model, check MEM->WB regs
  task automatic step();
    bit ld, st, sgn, err, we;
    int sz;
    logic [31:0] off, rt, ldv, word_after, wbase;
    #2;
    ld  = instr_mem inside {I_LW, I_LH, I_LHU, I_LB, I_LBU};
    st  = instr_mem inside {I_SW, I_SH, I_SB};
    sgn = instr_mem inside {I_LH, I_LB};
    sz  = (instr_mem inside {I_LH, I_LHU, I_SH}) ? 2 :
          (instr_mem inside {I_LB, I_LBU, I_SB}) ? 1 : 4;
    off = alu_out_mem - BASE;
    err = (ld || st) && (off >= NBYTE || (off % sz) != 0);
    rt  = (regaddr_wb == addr_rt_mem && regaddr_wb != 0) ? regdata_wb : mem_write_data_mem;
    we  = !reset && !stall && st && !err;
    ldv = 32'd0;
    if (ld && !err) begin
      for (int k = 0; k < sz; k++) ldv = ldv | (32'(mb[off + k]) << (8 * k));
      if (sgn && ldv[8*sz-1]) ldv = ldv | (32'hFFFF_FFFF << (8 * sz));
    end
    check("addr_err", 32'(addr_err), 32'(err));
    check("mem_we", 32'(mem_we), 32'(we));
    check("regaddr_fwd", 32'(regaddr_fwd), (tnew_mem == 0) ? 32'(reg_write_addr_mem) : 32'd0);
    check("regdata_fwd", regdata_fwd, reg_write_data_mem);
    if (we) begin
      wbase = off & ~32'd3;
      for (int k = 0; k < 4; k++) begin
        if (wbase + k >= off && wbase + k < off + sz)
          word_after[8*k +: 8] = rt[8*(wbase + k - off) +: 8];
        else
          word_after[8*k +: 8] = mb[wbase + k];
      end
      check("mem_addr", mem_addr, alu_out_mem & ~32'd3);
      check("mem_wdata", mem_wdata, word_after);
    end
    @(posedge clk);
    if (reset) begin
      for (int i = 0; i < NBYTE; i++) mb[i] = 8'd0;
    end else if (we) begin
      for (int k = 0; k < sz; k++) mb[off + k] = rt[8*k +: 8];
    end
    if (reset || clr) begin
      m_instr = '0; m_pc = '0; m_wa = '0; m_wd = '0; m_tn = '0;
    end else if (!stall) begin
      m_instr = instr_mem; m_pc = pc_mem; m_wa = reg_write_addr_mem;
      m_wd = ld ? ldv : reg_write_data_mem;
      m_tn = (tnew_mem >= 1) ? tnew_mem - 1 : 0;
    end
    #1;
    check("instr_wb", 32'(instr_wb), 32'(m_instr));
    check("pc_wb", pc_wb, m_pc);
    check("reg_write_addr_wb", 32'(reg_write_addr_wb), 32'(m_wa));
    check("reg_write_data_wb", reg_write_data_wb, m_wd);
    check("tnew_wb", 32'(tnew_wb), 32'(m_tn));
    $display("[TB] t=%0t op=%0d addr=%08h rst=%0b stl=%0b clr=%0b we=%0b err=%0b wb_data=%08h",
             $time, instr_mem, alu_out_mem, reset, stall, clr, we, err, reg_write_data_wb);
  endtask

  initial begin
    logic [WIDTH_INSTR-1:0] ops [11];
    ops = '{I_NOP, I_ADD, I_LW, I_LH, I_LHU, I_LB, I_LBU, I_SW, I_SH, I_SB, I_ORI};
    for (int i = 0; i < NBYTE; i++) mb[i] = 8'd0;
    m_instr = '0; m_pc = '0; m_wa = '0; m_wd = '0; m_tn = '0;
    pc_mem = 32'h0000_3000;
    set(I_NOP, 0, 0);
    reset = 1'b1;
    step();
    check("rst_wd", reg_write_data_wb, 32'd0);

    set(I_SW, 32'h10, 32'h1234_5678);                       step();
    set(I_LW, 32'h10, 0);                                   step();
    check("lw_word", reg_write_data_wb, 32'h1234_5678);
    set(I_SB, 32'h11, 32'h0000_00AB);                       step();
    set(I_LB, 32'h11, 0);                                   step();
    check("lb_sext", reg_write_data_wb, 32'hFFFF_FFAB);
    set(I_LBU, 32'h11, 0);                                  step();
    check("lbu_zext", reg_write_data_wb, 32'h0000_00AB);
    set(I_SH, 32'h12, 32'h0000_8001);                       step();
    set(I_LH, 32'h12, 0);                                   step();
    check("lh_sext", reg_write_data_wb, 32'hFFFF_8001);
    set(I_LHU, 32'h12, 0);                                  step();
    check("lhu_zext", reg_write_data_wb, 32'h0000_8001);
    set(I_LW, 32'h10, 0);                                   step();
    check("merged_word", reg_write_data_wb, 32'h8001_AB78);
    set(I_LW, 32'h13, 0, 0, 0, 0, 0, 32'h5A5A_5A5A);        step();
    check("lw_misalign", reg_write_data_wb, 32'd0);
    set(I_SW, NBYTE, 32'hDEAD_BEEF);                        step();

    set(I_SW, 32'h20, 32'h1111_1111, 5, 5, 32'hCAFE_0000);  step();
    set(I_LW, 32'h20, 0);                                   step();
    check("st_fwd_wb", reg_write_data_wb, 32'hCAFE_0000);
    set(I_SW, 32'h20, 32'h1111_1111, 0, 0, 32'hCAFE_0000);  step();
    set(I_LW, 32'h20, 0);                                   step();
    check("st_fwd_zero", reg_write_data_wb, 32'h1111_1111);

    set(I_SW, 32'h24, 32'h0000_5555, 0, 0, 0, 3, 32'h77);
    stall = 1'b1; step(); step(); step();
    stall = 1'b0; step();
    set(I_LW, 32'h24, 0);                                   step();
    check("stall_store", reg_write_data_wb, 32'h0000_5555);
    set(I_ADD, 0, 0, 0, 0, 0, 9, 32'h1234);
    clr = 1'b1; step();
    check("clr_wa", 32'(reg_write_addr_wb), 32'd0);

    set(I_SW, 32'h28, 32'h9999_9999);                       step();
    set(I_NOP, 0, 0); reset = 1'b1;                         step();
    set(I_LW, 32'h28, 0);                                   step();
    check("rst_clears", reg_write_data_wb, 32'd0);
    set(I_ADD, 0, 0, 0, 0, 0, 7, 32'hABCD, 0);              step();

    for (int n = 0; n < 2000; n++) begin
      logic [31:0] a;
      a = ($urandom_range(0, 15) == 0) ? (NBYTE - 8 + $urandom_range(0, 15)) : $urandom_range(0, 63);
      set(ops[$urandom_range(0, 10)], a, $urandom,
          5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), $urandom,
          5'($urandom_range(0, 31)), $urandom, WIDTH_T'($urandom_range(0, 3)));
      stall = ($urandom_range(0, 4) == 0);
      clr   = ($urandom_range(0, 7) == 0);
      reset = ($urandom_range(0, 49) == 0);
      step();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
